// File: rtl/sle_pkg.sv
// Shared types for the sle bank loader: command opcodes and controller states.
package sle_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SCLR  = 2'b01,
        OP_SSET  = 2'b10,
        OP_SHIFT = 2'b11
    } sle_op_e;

    typedef enum logic [2:0] {
        ST_RST_REL,
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT,
        ST_CHECK
    } sle_ldr_state_e;

endpackage

// File: rtl/sle_bank_loader.sv
// Command-driven controller for a bank of sle elements: parallel write, sync clear/set,
// MSB-first serial shift-in, and a readback check one cycle after each operation.
module sle_bank_loader
    import sle_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] sle_d,
    output logic [WIDTH-1:0] sle_en,
    output logic             sle_sln,
    output logic             sle_sd,
    output logic             sle_lat,
    output logic             sle_aln,
    output logic             sle_adn,
    input  logic [WIDTH-1:0] sle_q,
    output logic             done,
    output logic             err,
    input  logic             err_clr
);

    localparam int K_W = $clog2(WIDTH);
    localparam logic [K_W-1:0] K_LAST = K_W'(WIDTH - 1);

    sle_ldr_state_e   state, state_n;
    sle_op_e          op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] exp_q;
    logic [K_W-1:0]   k;
    logic             aln_q;
    logic             accept;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign done      = (state == ST_CHECK);
    assign sle_lat   = 1'b0;
    assign sle_adn   = 1'b1;
    assign sle_aln   = aln_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RST_REL;
            op_q   <= OP_WRITE;
            data_q <= '0;
            exp_q  <= '0;
            k      <= '0;
            err    <= 1'b0;
            aln_q  <= 1'b0;
        end else begin
            state <= state_n;
            aln_q <= 1'b1;
            if (accept) begin
                op_q   <= sle_op_e'(cmd_op);
                data_q <= cmd_data;
                case (sle_op_e'(cmd_op))
                    OP_SCLR: exp_q <= '0;
                    OP_SSET: exp_q <= '1;
                    default: exp_q <= cmd_data;
                endcase
            end
            if (state == ST_SHIFT) begin
                k <= (k == K_LAST) ? '0 : k + 1'b1;
            end
            // A mismatch in CHECK takes priority over a coincident clear.
            if (state == ST_CHECK && sle_q != exp_q) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_n = state;
        sle_en  = '0;
        sle_d   = '0;
        sle_sln = 1'b1;
        sle_sd  = 1'b0;
        case (state)
            ST_RST_REL: state_n = ST_IDLE;
            ST_IDLE: begin
                if (accept) begin
                    state_n = (sle_op_e'(cmd_op) == OP_SHIFT) ? ST_SHIFT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_n = ST_CHECK;
                sle_en  = '1;
                case (op_q)
                    OP_SCLR: sle_sln = 1'b0;
                    OP_SSET: begin
                        sle_sln = 1'b0;
                        sle_sd  = 1'b1;
                    end
                    default: sle_d = data_q;
                endcase
            end
            ST_SHIFT: begin
                if (k == K_LAST) begin
                    state_n = ST_CHECK;
                end
                sle_en = '1;
                // Bank shifts toward the MSB; the next data bit enters at element 0.
                sle_d  = {sle_q[WIDTH-2:0], data_q[K_LAST - k]};
            end
            ST_CHECK: state_n = ST_IDLE;
            default:  state_n = ST_RST_REL;
        endcase
    end

endmodule
